// File: rtl/wakeup_isq.sv
// Issue queue with tag-broadcast wakeup, age-matrix oldest-first select and
// ROB-id based flush of younger entries.
module wakeup_isq #(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int PREG_WIDTH  = 6,
    parameter int ROBID_WIDTH = 7,
    parameter int NUM_WB      = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enq_valid,
    output logic                                enq_ready,
    input  logic [DATA_WIDTH-1:0]               enq_data,
    input  logic [ROBID_WIDTH-1:0]              enq_robid,
    input  logic [PREG_WIDTH-1:0]               enq_prs1,
    input  logic [PREG_WIDTH-1:0]               enq_prs2,
    input  logic                                enq_rdy1,
    input  logic                                enq_rdy2,
    output logic                                deq_valid,
    input  logic                                deq_ready,
    output logic [DATA_WIDTH-1:0]               deq_data,
    output logic [ROBID_WIDTH-1:0]              deq_robid,
    input  logic [NUM_WB-1:0]                   wb_valid,
    input  logic [NUM_WB-1:0][PREG_WIDTH-1:0]   wb_prd,
    input  logic                                flush_valid,
    input  logic [ROBID_WIDTH-1:0]              flush_robid,
    output logic [$clog2(DEPTH):0]              count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = ROBID_WIDTH - 1;

    logic [DEPTH-1:0]       valid_reg;
    logic [DEPTH-1:0]       valid_next;
    logic [DEPTH-1:0]       elig;
    logic [DEPTH-1:0]       sel_oh;
    logic [DEPTH-1:0]       free_vec;
    logic [DEPTH-1:0]       enq_oh;
    logic [DATA_WIDTH-1:0]  data_reg  [DEPTH];
    logic [ROBID_WIDTH-1:0] robid_reg [DEPTH];
    logic [PREG_WIDTH-1:0]  prs1_reg  [DEPTH];
    logic [PREG_WIDTH-1:0]  prs2_reg  [DEPTH];
    logic                   rdy1_reg  [DEPTH];
    logic                   rdy2_reg  [DEPTH];
    // older_reg[j][i] set means entry j was enqueued before entry i
    logic [DEPTH-1:0]       older_reg [DEPTH];
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic                   enq_fire;
    logic                   deq_fire;
    logic                   enq_wake1;
    logic                   enq_wake2;

    function automatic logic is_younger(input logic [ROBID_WIDTH-1:0] a,
                                        input logic [ROBID_WIDTH-1:0] b);
        if (a[ROBID_WIDTH-1] == b[ROBID_WIDTH-1])
            return a[IW-1:0] > b[IW-1:0];
        return a[IW-1:0] < b[IW-1:0];
    endfunction

    assign count     = count_reg;
    assign enq_ready = (count_reg < CW'(DEPTH)) && !flush_valid;
    assign enq_fire  = enq_valid && enq_ready;
    assign free_vec  = ~valid_reg;
    assign enq_oh    = free_vec & (~free_vec + DEPTH'(1));
    assign deq_valid = (|elig) && !flush_valid;
    assign deq_fire  = deq_valid && deq_ready;

    // Bypass: an entry being written also catches wakeups broadcast this cycle
    always_comb begin
        enq_wake1 = 1'b0;
        enq_wake2 = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && (wb_prd[p] == enq_prs1)) enq_wake1 = 1'b1;
            if (wb_valid[p] && (wb_prd[p] == enq_prs2)) enq_wake2 = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wake1;
            logic wake2;
            logic blocked;
            logic enq_hit;
            logic deq_hit;
            logic flush_hit;

            always_comb begin
                wake1 = 1'b0;
                wake2 = 1'b0;
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid[p] && (wb_prd[p] == prs1_reg[gi])) wake1 = 1'b1;
                    if (wb_valid[p] && (wb_prd[p] == prs2_reg[gi])) wake2 = 1'b1;
                end
            end

            always_comb begin
                blocked = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (elig[j] && older_reg[j][gi]) blocked = 1'b1;
                end
            end

            assign elig[gi]       = valid_reg[gi] && rdy1_reg[gi] && rdy2_reg[gi];
            assign sel_oh[gi]     = elig[gi] && !blocked;
            assign enq_hit        = enq_fire && enq_oh[gi];
            assign deq_hit        = deq_fire && sel_oh[gi];
            assign flush_hit      = flush_valid && is_younger(robid_reg[gi], flush_robid);
            assign valid_next[gi] = enq_hit || (valid_reg[gi] && !deq_hit && !flush_hit);

            always_ff @(posedge clock) begin
                if (reset) begin
                    rdy1_reg[gi]  <= 1'b0;
                    rdy2_reg[gi]  <= 1'b0;
                    older_reg[gi] <= '0;
                end else if (enq_hit) begin
                    data_reg[gi]  <= enq_data;
                    robid_reg[gi] <= enq_robid;
                    prs1_reg[gi]  <= enq_prs1;
                    prs2_reg[gi]  <= enq_prs2;
                    rdy1_reg[gi]  <= enq_rdy1 || enq_wake1;
                    rdy2_reg[gi]  <= enq_rdy2 || enq_wake2;
                    older_reg[gi] <= '0;
                end else begin
                    if (wake1) rdy1_reg[gi] <= 1'b1;
                    if (wake2) rdy2_reg[gi] <= 1'b1;
                    if (enq_fire) older_reg[gi] <= older_reg[gi] | enq_oh;
                end
            end
        end
    endgenerate

    always_comb begin
        deq_data  = '0;
        deq_robid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                deq_data  = deq_data | data_reg[i];
                deq_robid = deq_robid | robid_reg[i];
            end
        end
    end

    assign count_next = CW'($countones(valid_next));

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end
endmodule
